// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and helpers for the sprite ROM arbiter and
// the other round-robin arbiters in the video pipeline.
package sprite_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int SPR_ROM_LAT = 1;

    // Behavioural one-hot pick for up to 8 requesters.
    function automatic logic [7:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        logic [7:0] oh;
        int         j;
        oh = '0;
        for (int k = 0; k < n; k++) begin
            j = (int'(ptr) + k) % n;
            if (req[j] && oh == '0)
                oh[j] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin one-hot picker: rotate by ptr,
// priority-encode the lowest bit, rotate back.
module rr_pick_onehot #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int             p;
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        p   = int'(ptr) % N;
        dbl = {req, req} >> p;
        rot = dbl[N-1:0];
        idx = '0;
        gnt = '0;
        any = |rot;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k])
                idx = PW'((k + p) % N);
        end
        if (any)
            gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between N_REQ engines with
// round-robin grants, capped locked bursts and tagged responses.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDRW     = 6,
    parameter int SPR_DATAW = 3,
    parameter int ROM_LAT   = SPR_ROM_LAT,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*ADDRW-1:0] req_addr,
    output logic [N_REQ-1:0]       gnt,
    output logic [ADDRW-1:0]       rom_addr,
    output logic                   rom_rd,
    input  logic [SPR_DATAW-1:0]   rom_data,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [SPR_DATAW-1:0]   rsp_data,
    output logic                   busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [CW-1:0]    burst_cnt;
    logic [N_REQ-1:0] pipe [ROM_LAT];

    logic [N_REQ-1:0] pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic             held;
    logic             pipe_any;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
        return (int'(x) == N_REQ - 1) ? '0 : x + PW'(1);
    endfunction

    rr_pick_onehot #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign held = req[owner] & lock[owner];

    always_comb begin
        gnt = '0;
        if (!rst && !line) begin
            unique case (state)
                IDLE:  gnt = pick_gnt;
                BURST: gnt[owner] = held;
            endcase
        end
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i])
                rom_addr |= req_addr[i*ADDRW +: ADDRW];
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < ROM_LAT; i++)
            pipe_any |= |pipe[i];
    end

    assign rom_rd    = |gnt;
    assign rsp_valid = pipe[ROM_LAT-1];
    assign rsp_data  = (|rsp_valid) ? rom_data : '0;
    assign busy      = rom_rd | pipe_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            for (int i = 0; i < ROM_LAT; i++)
                pipe[i] <= '0;
        end else begin
            // line re-seeds arbitration but lets in-flight reads finish
            pipe[0] <= gnt;
            for (int i = 1; i < ROM_LAT; i++)
                pipe[i] <= pipe[i-1];
            if (line) begin
                state     <= IDLE;
                ptr       <= '0;
                burst_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pick_any) begin
                            if (lock[pick_idx] && MAX_BURST > 1) begin
                                owner     <= pick_idx;
                                burst_cnt <= CW'(1);
                                state     <= BURST;
                            end else begin
                                ptr <= nxt(pick_idx);
                            end
                        end
                    end
                    BURST: begin
                        if (!held ||
                            burst_cnt == CW'(MAX_BURST - 1)) begin
                            state     <= IDLE;
                            ptr       <= nxt(owner);
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
